// File: rtl/seg_page_scheduler.sv
// Seven-segment page scheduler: round-robin over valid debug sources,
// with a per-page dwell time and an optional blank gap between pages.
module seg_page_scheduler #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned BLANK_CYCLES = 5_000_000
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [32*NUM_SRC-1:0]      src_val_in,
  input  logic [NUM_SRC-1:0]         src_valid_in,
  input  logic                       btn_next_in,
  input  logic                       hold_in,
  output logic [31:0]                val_out,
  output logic                       en_out,
  output logic [$clog2(NUM_SRC)-1:0] page_out
);

  localparam int unsigned PW = $clog2(NUM_SRC);
  localparam logic [31:0] DW_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] BL_LAST = 32'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [PW-1:0]   r_page, w_page;
  logic [31:0]     r_val, w_val;
  logic            r_en, w_en;
  logic [31:0]     r_dwell, w_dwell;
  logic [31:0]     r_blank, w_blank;

  logic [PW-1:0]   w_low;
  logic            w_any;
  logic [PW-1:0]   w_target;
  logic            w_other;
  logic            w_adv;

  // Lowest valid index, and first valid index after the current page.
  always_comb begin
    w_low    = '0;
    w_any    = |src_valid_in;
    w_target = r_page;
    w_other  = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid_in[i]) w_low = PW'(i);
    end
    for (int k = NUM_SRC - 1; k >= 1; k--) begin
      if (src_valid_in[(int'(r_page) + k) % NUM_SRC]) begin
        w_other  = 1'b1;
        w_target = PW'((int'(r_page) + k) % NUM_SRC);
      end
    end
  end

  assign w_adv = btn_next_in || (!hold_in && r_dwell == DW_LAST);

  always_comb begin
    w_state = r_state;
    w_page  = r_page;
    w_val   = r_val;
    w_en    = r_en;
    w_dwell = r_dwell;
    w_blank = r_blank;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_page  = w_low;
          w_val   = src_val_in[32*int'(w_low) +: 32];
          w_state = SHOW;
          w_en    = 1'b1;
          w_dwell = '0;
        end
      end
      SHOW: begin
        if (src_valid_in[r_page])
          w_val = src_val_in[32*int'(r_page) +: 32];
        if (w_adv) begin
          w_dwell = '0;
          if (w_other) begin
            w_page = w_target;
            if (BLANK_CYCLES > 0) begin
              w_state = BLANK;
              w_en    = 1'b0;
              w_blank = '0;
            end
          end else if (!src_valid_in[r_page]) begin
            w_state = IDLE;
            w_en    = 1'b0;
          end
        end else if (!hold_in) begin
          w_dwell = r_dwell + 32'd1;
        end
      end
      BLANK: begin
        if (src_valid_in[r_page])
          w_val = src_val_in[32*int'(r_page) +: 32];
        if (r_blank == BL_LAST) begin
          w_state = SHOW;
          w_en    = 1'b1;
          w_blank = '0;
          w_dwell = '0;
        end else begin
          w_blank = r_blank + 32'd1;
        end
      end
      default: begin
        w_state = IDLE;
        w_en    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_page  <= '0;
      r_val   <= '0;
      r_en    <= 1'b0;
      r_dwell <= '0;
      r_blank <= '0;
    end else begin
      r_state <= w_state;
      r_page  <= w_page;
      r_val   <= w_val;
      r_en    <= w_en;
      r_dwell <= w_dwell;
      r_blank <= w_blank;
    end
  end

  assign val_out  = r_val;
  assign en_out   = r_en;
  assign page_out = r_page;

endmodule

// File: tb/tb_seg_page_scheduler.sv
// Directed bench for seg_page_scheduler (NUM_SRC=4, DWELL=8, BLANK=2):
// expected outputs are queued per cycle and compared after each edge.
module tb_seg_page_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] src_val = '0;
  logic [3:0]   src_valid = '0;
  logic         btn = 1'b0;
  logic         hold = 1'b0;
  logic [31:0]  val;
  logic         en;
  logic [1:0]   page;

  typedef struct packed {
    logic        en;
    logic [1:0]  page;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  seg_page_scheduler #(
    .NUM_SRC(4),
    .DWELL_CYCLES(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .src_val_in(src_val),
    .src_valid_in(src_valid),
    .btn_next_in(btn),
    .hold_in(hold),
    .val_out(val),
    .en_out(en),
    .page_out(page)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string tag, input logic e,
                     input logic [1:0] p, input logic [31:0] v);
    exp_t x;
    q.push_back('{en: e, page: p, val: v});
    @(posedge clk);
    #1;
    x = q.pop_front();
    n_vec += 3;
    assert (en === x.en) else begin
      n_err++;
      $error("FAIL %s en got %0b exp %0b", tag, en, x.en);
    end
    assert (page === x.page) else begin
      n_err++;
      $error("FAIL %s page got %0d exp %0d", tag, page, x.page);
    end
    assert (val === x.val) else begin
      n_err++;
      $error("FAIL %s val got %h exp %h", tag, val, x.val);
    end
  endtask

  task automatic rep(input string tag, input int n, input logic e,
                     input logic [1:0] p, input logic [31:0] v);
    for (int i = 0; i < n; i++) cyc(tag, e, p, v);
  endtask

  initial begin
    rep("reset", 2, 1'b0, 2'd0, 32'h0);
    rst = 1'b0;

    rep("idle", 20, 1'b0, 2'd0, 32'h0);

    src_val[31:0]  = 32'h11111111;
    src_val[95:64] = 32'h22222222;
    src_valid = 4'b0101;
    rep("show0", 8, 1'b1, 2'd0, 32'h11111111);
    cyc("blank0a", 1'b0, 2'd2, 32'h11111111);
    cyc("blank0b", 1'b0, 2'd2, 32'h22222222);
    rep("show2", 8, 1'b1, 2'd2, 32'h22222222);
    cyc("blank2a", 1'b0, 2'd0, 32'h22222222);
    cyc("blank2b", 1'b0, 2'd0, 32'h11111111);
    cyc("back0", 1'b1, 2'd0, 32'h11111111);

    src_val[127:96] = 32'h33333333;
    src_valid = 4'b1000;
    rep("stale0", 7, 1'b1, 2'd0, 32'h11111111);
    cyc("to3a", 1'b0, 2'd3, 32'h11111111);
    cyc("to3b", 1'b0, 2'd3, 32'h33333333);
    cyc("show3", 1'b1, 2'd3, 32'h33333333);
    rep("solo3", 24, 1'b1, 2'd3, 32'h33333333);

    src_valid = 4'b0101;
    btn = 1'b1;
    cyc("btn3", 1'b0, 2'd0, 32'h33333333);
    btn = 1'b0;
    cyc("btn3b", 1'b0, 2'd0, 32'h11111111);
    cyc("h_show", 1'b1, 2'd0, 32'h11111111);
    hold = 1'b1;
    rep("hold", 50, 1'b1, 2'd0, 32'h11111111);
    btn = 1'b1;
    cyc("hold_btn", 1'b0, 2'd2, 32'h11111111);
    btn = 1'b0;
    cyc("hold_bl", 1'b0, 2'd2, 32'h22222222);
    cyc("hold_s2", 1'b1, 2'd2, 32'h22222222);
    hold = 1'b0;

    src_val[63:32] = 32'h44444444;
    src_valid = 4'b0010;
    btn = 1'b1;
    cyc("to1a", 1'b0, 2'd1, 32'h22222222);
    btn = 1'b0;
    cyc("to1b", 1'b0, 2'd1, 32'h44444444);
    cyc("show1", 1'b1, 2'd1, 32'h44444444);
    src_valid = 4'b1111;
    rep("dw1", 7, 1'b1, 2'd1, 32'h44444444);
    btn = 1'b1;
    cyc("dbl_adv", 1'b0, 2'd2, 32'h44444444);
    btn = 1'b0;
    cyc("dbl_bl", 1'b0, 2'd2, 32'h22222222);
    cyc("dbl_s2", 1'b1, 2'd2, 32'h22222222);

    src_val[95:64] = 32'hDEADBEEF;
    cyc("dead", 1'b1, 2'd2, 32'hDEADBEEF);
    src_valid = 4'b0000;
    rep("stale2", 6, 1'b1, 2'd2, 32'hDEADBEEF);
    rep("to_idle", 3, 1'b0, 2'd2, 32'hDEADBEEF);

    src_valid = 4'b0101;
    cyc("re_show", 1'b1, 2'd0, 32'h11111111);
    btn = 1'b1;
    cyc("re_blank", 1'b0, 2'd2, 32'h11111111);
    btn = 1'b0;
    rst = 1'b1;
    src_valid = 4'b0000;
    cyc("rst_blank", 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    rep("post_rst", 2, 1'b0, 2'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
